// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into click, double-click and long-press events.
// Event pulses and the hold/busy levels all come straight from flops.
module key_event_decoder #(
    parameter int unsigned TICK_DIV   = 2_000_000,
    parameter int unsigned LONG_TICKS = 50,
    parameter int unsigned DBL_TICKS  = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    output logic click_o,
    output logic dbl_click_o,
    output logic long_o,
    output logic hold_o,
    output logic busy_o
);

    localparam int unsigned PW        = 32;
    localparam int unsigned MAX_TICKS = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
    localparam int unsigned TW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_tcnt;
    logic          r_key_d;

    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_long_to;
    logic w_dbl_to;

    assign w_tick    = (r_pre == PW'(TICK_DIV - 1));
    assign w_rise    = key_level & ~r_key_d;
    assign w_fall    = ~key_level & r_key_d;
    assign w_long_to = w_tick && (r_tcnt == TW'(LONG_TICKS - 1));
    assign w_dbl_to  = w_tick && (r_tcnt == TW'(DBL_TICKS - 1));

    // Free-running tick prescaler; the FSM never restarts it, hence the one-tick phase slack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_key_d <= 1'b0;
        end else begin
            r_key_d <= key_level;
            if (w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    // Gesture FSM; every transition clears tcnt, and an edge always beats a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            click_o     <= 1'b0;
            dbl_click_o <= 1'b0;
            long_o      <= 1'b0;
            hold_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            click_o     <= 1'b0;
            dbl_click_o <= 1'b0;
            long_o      <= 1'b0;
            if (w_tick && (r_tcnt != {TW{1'b1}})) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_PRESS1;
                        r_tcnt  <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                S_PRESS1: begin
                    if (w_fall) begin
                        r_state <= S_WAIT2;
                        r_tcnt  <= '0;
                    end else if (w_long_to) begin
                        r_state <= S_LONG;
                        r_tcnt  <= '0;
                        long_o  <= 1'b1;
                        hold_o  <= 1'b1;
                    end
                end
                S_WAIT2: begin
                    if (w_rise) begin
                        r_state <= S_PRESS2;
                        r_tcnt  <= '0;
                    end else if (w_dbl_to) begin
                        r_state <= S_IDLE;
                        r_tcnt  <= '0;
                        click_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                S_PRESS2: begin
                    if (w_fall) begin
                        r_state     <= S_IDLE;
                        r_tcnt      <= '0;
                        dbl_click_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else if (w_long_to) begin
                        r_state <= S_LONG;
                        r_tcnt  <= '0;
                        long_o  <= 1'b1;
                        hold_o  <= 1'b1;
                    end
                end
                S_LONG: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                        r_tcnt  <= '0;
                        hold_o  <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tcnt  <= '0;
                    hold_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with TICK_DIV=10, LONG_TICKS=5, DBL_TICKS=3.
// Inputs change 1 time unit after a rising edge; outputs are observed on the falling edge.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic key_level;
    logic click_o;
    logic dbl_click_o;
    logic long_o;
    logic hold_o;
    logic busy_o;

    key_event_decoder #(
        .TICK_DIV   (10),
        .LONG_TICKS (5),
        .DBL_TICKS  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_level   (key_level),
        .click_o     (click_o),
        .dbl_click_o (dbl_click_o),
        .long_o      (long_o),
        .hold_o      (hold_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    int   n_click = 0;
    int   n_dbl   = 0;
    int   n_long  = 0;
    int   n_excl  = 0;
    int   t_click = -1;
    int   t_dbl   = -1;
    int   t_long  = -1;
    int   t_busy_fall = -1;
    logic busy_q  = 1'b0;

    // Event recorder: counts pulses and stamps the cycle each was seen in.
    always @(negedge clk) begin
        if (click_o === 1'b1) begin
            n_click = n_click + 1;
            t_click = cyc;
        end
        if (dbl_click_o === 1'b1) begin
            n_dbl = n_dbl + 1;
            t_dbl = cyc;
        end
        if (long_o === 1'b1) begin
            n_long = n_long + 1;
            t_long = cyc;
        end
        if ((int'(click_o) + int'(dbl_click_o) + int'(long_o)) > 1) n_excl = n_excl + 1;
        if (busy_q && (busy_o === 1'b0)) t_busy_fall = cyc;
        busy_q = (busy_o === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int rel;
    int c0, d0, l0;
    int r_cyc, p_cyc, t_edge, t5;

    initial begin
        rst_n     = 1'b0;
        key_level = 1'b0;
        step(3);
        check("rst_click", 32'(click_o), 32'd0);
        check("rst_dbl",   32'(dbl_click_o), 32'd0);
        check("rst_long",  32'(long_o), 32'd0);
        check("rst_hold",  32'(hold_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        rst_n = 1'b1;
        rel   = cyc;
        step(5);

        // Single click
        c0 = n_click; d0 = n_dbl; l0 = n_long;
        key_level = 1'b1;
        step(20);
        key_level = 1'b0;
        r_cyc = cyc;
        step(40);
        check("click_cnt",   32'(n_click - c0), 32'd1);
        check("click_delay", 32'((t_click - r_cyc >= 21) && (t_click - r_cyc <= 31)), 32'd1);
        check("click_busy",  32'(t_busy_fall), 32'(t_click));
        check("click_other", 32'((n_dbl - d0) + (n_long - l0)), 32'd0);

        // Double click
        c0 = n_click; d0 = n_dbl; l0 = n_long;
        key_level = 1'b1;
        step(15);
        key_level = 1'b0;
        step(12);
        key_level = 1'b1;
        step(15);
        key_level = 1'b0;
        r_cyc = cyc;
        step(40);
        check("dbl_cnt",   32'(n_dbl - d0), 32'd1);
        check("dbl_time",  32'(t_dbl), 32'(r_cyc + 1));
        check("dbl_busy",  32'(t_busy_fall), 32'(t_dbl));
        check("dbl_other", 32'((n_click - c0) + (n_long - l0)), 32'd0);

        // Long press
        c0 = n_click; d0 = n_dbl; l0 = n_long;
        key_level = 1'b1;
        p_cyc = cyc;
        step(100);
        check("long_hold_on", 32'(hold_o), 32'd1);
        key_level = 1'b0;
        step(1);
        check("long_hold_off", 32'(hold_o), 32'd0);
        check("long_busy_off", 32'(busy_o), 32'd0);
        check("long_cnt",   32'(n_long - l0), 32'd1);
        check("long_delay", 32'((t_long - p_cyc >= 41) && (t_long - p_cyc <= 51)), 32'd1);
        check("long_other", 32'((n_click - c0) + (n_dbl - d0)), 32'd0);
        step(5);

        // Gap too long for a double click
        c0 = n_click; d0 = n_dbl; l0 = n_long;
        key_level = 1'b1;
        step(15);
        key_level = 1'b0;
        step(40);
        key_level = 1'b1;
        step(15);
        key_level = 1'b0;
        step(40);
        check("gap_clicks", 32'(n_click - c0), 32'd2);
        check("gap_dbl",    32'(n_dbl - d0), 32'd0);

        // Fall sampled on the very tick that would hit the long threshold
        c0 = n_click; d0 = n_dbl; l0 = n_long;
        key_level = 1'b1;
        p_cyc  = cyc;
        t_edge = p_cyc + 2;
        while (((t_edge - rel) % 10) != 0) t_edge = t_edge + 1;
        t5 = t_edge + 40;
        step(t5 - 1 - cyc);
        key_level = 1'b0;
        step(45);
        check("tie_long",  32'(n_long - l0), 32'd0);
        check("tie_click", 32'(n_click - c0), 32'd1);
        check("tie_ctime", 32'(t_click), 32'(t5 + 30));

        // Reset while in PRESS2 with the key still held
        c0 = n_click; d0 = n_dbl; l0 = n_long;
        key_level = 1'b1;
        step(15);
        key_level = 1'b0;
        step(12);
        key_level = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy_o), 32'd0);
        check("arst_hold",   32'(hold_o), 32'd0);
        check("arst_pulses", 32'(int'(click_o) + int'(dbl_click_o) + int'(long_o)), 32'd0);
        step(3);
        rst_n = 1'b1;
        rel   = cyc;
        step(1);
        check("arst_rerise", 32'(busy_o), 32'd1);
        check("arst_noevt",  32'((n_click - c0) + (n_dbl - d0) + (n_long - l0)), 32'd0);
        step(10);
        key_level = 1'b0;
        step(40);
        check("arst_click", 32'(n_click - c0), 32'd1);
        check("arst_dbl",   32'(n_dbl - d0), 32'd0);

        check("exclusive", 32'(n_excl), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes the debounced key level produced by the team's button debouncer and classifies each user gesture as a single click, a double click or a long press. It sits between the debounced key input and the control/menu logic. It emits one-cycle event pulses plus a hold level. All timing is derived from a 20 ms tick at 100 MHz, the same scan rate as the debouncer.

## Interface
- TICK_DIV, 2_000_000: clk cycles per tick (100 MHz / 50 Hz).
- LONG_TICKS, 50: ticks a press must last to count as long (1 s).
- DBL_TICKS, 15: maximum release-to-second-press gap in ticks (300 ms).
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- key_level  in  1  debounced key, 1 = pressed; synchronous to clk.
- click_o  out  1  one-cycle pulse on a single click.
- dbl_click_o  out  1  one-cycle pulse on a double click.
- long_o  out  1  one-cycle pulse when the long-press threshold is reached.
- hold_o  out  1  level, high while in LONG.
- busy_o  out  1  level, high whenever the state is not IDLE.

## Operation
- **Prescaler:** free-running 32-bit counter, 0..TICK_DIV-1. tick = 1 for one cycle at terminal count. It is never cleared by the FSM.
- **Edge detect:** key_d <= key_level. rise = key_level & ~key_d; fall = ~key_level & key_d.
- **Tick counter (tcnt):**
  - Width $clog2(max(LONG_TICKS, DBL_TICKS)+1).
  - Cleared on every state change; otherwise increments on tick.
  - "Timeout(N)" means tick = 1 and tcnt == N-1 in the same cycle.
  - Saturates and never wraps.
- **FSM states:** IDLE, PRESS1, WAIT2, PRESS2, LONG.
  - IDLE: rise -> PRESS1.
  - PRESS1: fall -> WAIT2. Timeout(LONG_TICKS) -> pulse long_o, go to LONG.
  - WAIT2: rise -> PRESS2. Timeout(DBL_TICKS) -> pulse click_o, go to IDLE.
  - PRESS2: fall -> pulse dbl_click_o, go to IDLE. Timeout(LONG_TICKS) -> pulse long_o, go to LONG; no click or double click is reported.
  - LONG: fall -> IDLE. No further pulses while held.
- **Simultaneous edge and timeout:** the edge wins. For example, fall in PRESS1 in the same cycle as Timeout(LONG_TICKS) goes to WAIT2 with no long_o.
- **Output exclusivity:** at most one of click_o, dbl_click_o, long_o is high in any cycle.
- **Reset:** asserting rst_n at any time, including mid-gesture, discards the gesture.
  - State returns to IDLE; prescaler, tcnt and key_d go to 0.
  - No event is emitted for the discarded gesture.
  - If the key is still held when reset is released, key_d = 0, so the held level is treated as a new rise on the first cycle.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Registered outputs:** all outputs come from flops.
  - A pulse is high exactly one cycle.
  - It appears on the clock edge that completes the transition, i.e. the cycle after the triggering key_level sample or tick.
- **Edge latency:** key_level change to state change is 1 clk for a rise or fall, since key_d adds the comparison cycle.
- **Long threshold:** press duration before long_o lies in ((LONG_TICKS-1)·TICK_DIV, LONG_TICKS·TICK_DIV] cycles, because of the free-running prescaler phase.
- **Click delay:** click_o is delayed after release by ((DBL_TICKS-1)·TICK_DIV, DBL_TICKS·TICK_DIV] cycles.
- **dbl_click_o:** asserted 1 clk after the second release is sampled.
- **busy_o:** rises 1 clk after the rise is detected and falls together with the final transition into IDLE.

## Test plan
Simulation parameters: TICK_DIV=10, LONG_TICKS=5, DBL_TICKS=3.
- **Single click:** press for 20 cycles, then release. -> Exactly one click_o pulse 21..31 cycles after the release; no other pulses; busy_o returns to 0 in the same cycle.
- **Double click:** press 15 cycles, release 12 cycles, press 15 cycles, release. -> dbl_click_o high for one cycle, 1 clk after the second release is sampled; click_o never asserts.
- **Long press:** hold for 100 cycles. -> long_o pulses once between 41 and 51 cycles after the press; hold_o = 1 until 1 clk after release, then IDLE; no other pulses.
- **Gap too long:** press 15 cycles, release 40 cycles, press 15 cycles, release. -> Two separate click_o pulses; no dbl_click_o.
- **Edge/timeout tie:** force the fall in PRESS1 to coincide with Timeout(5). -> No long_o; the FSM enters WAIT2, then click_o follows.
- **Reset mid-gesture:** in PRESS2, pull rst_n low for 3 cycles. -> All outputs 0 immediately (asynchronous), no event emitted afterward; with the key still held at reset release, a new rise is detected and the FSM goes to PRESS1.
